// File: rtl/tone_dds_pkg.sv
// Shared definitions for the tone DDS: FSM states, pipeline depth, midscale,
// dither LFSR constants and the quarter-wave sine magnitude generator.
package tone_dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } dds_state_e;

  localparam int          DDS_LATENCY   = 3;
  localparam int          DEFAULT_OUT_W = 12;
  localparam int          MIDSCALE      = 1 << (DEFAULT_OUT_W - 1);

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, taps at bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  // Magnitude of entry idx, sampled at bin centres so quadrant folding is symmetric.
  function automatic int sine_mag(input int idx, input int mag_w, input int aw);
    real amp;
    real ang;
    amp = real'((1 << mag_w) - 1);
    ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / real'(1 << aw);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave sine magnitude ROM with a registered read port (one-cycle latency).
module sine_qrom
  import tone_dds_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] rom [2**AW];
  logic [DW-1:0] data_q;

  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_rom
    assign rom[gi] = DW'(sine_mag(gi, DW, AW));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= rom[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/tone_dds.sv
// Sine tone DDS: phase accumulator, quarter-wave ROM lookup, offset-binary output.
// Define TONE_DDS_DITHER_EN to add LFSR phase dither on the truncated phase bits.
module tone_dds
  import tone_dds_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 12,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dds_ena,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  output logic               dds_rdy,
  output logic [OUT_W-1:0]   sample
);

  localparam logic [OUT_W-1:0] MID       = OUT_W'(1) << (OUT_W - 1);
  localparam logic [1:0]       FILL_LAST = 2'(DDS_LATENCY - 1);

  dds_state_e           state_q;
  logic [1:0]           fill_cnt_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [PHASE_W-1:0]   inc_q;
  logic [LUT_AW+1:0]    phase_hi;
  logic [LUT_AW-1:0]    addr_d;
  logic [LUT_AW-1:0]    addr_q;
  logic [1:0]           quad1_q;
  logic [1:0]           quad2_q;
  logic [OUT_W-2:0]     mag;
  logic [OUT_W-1:0]     sample_d;
  logic [OUT_W-1:0]     sample_q;
  logic                 dds_rdy_q;

`ifdef TONE_DDS_DITHER_EN
  localparam int                 TRUNC_W    = PHASE_W - 2 - LUT_AW;
  localparam logic [PHASE_W-1:0] TRUNC_MASK = (PHASE_W'(1) << TRUNC_W) - PHASE_W'(1);

  logic [15:0]        lfsr_q;
  logic [PHASE_W-1:0] phase_dith;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q != ST_IDLE) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // Dither only touches bits below the ROM address; a carry may bump the address.
  assign phase_dith = phase_q + (PHASE_W'(lfsr_q) & TRUNC_MASK);
  assign phase_hi   = phase_dith[PHASE_W-1 -: LUT_AW+2];
`else
  assign phase_hi   = phase_q[PHASE_W-1 -: LUT_AW+2];
`endif

  // Odd quadrants walk the quarter wave backwards.
  assign addr_d = phase_hi[LUT_AW-1:0] ^ {LUT_AW{phase_hi[LUT_AW]}};

  sine_qrom #(
    .AW (LUT_AW),
    .DW (OUT_W - 1)
  ) u_qrom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_i  (addr_q),
    .data_o  (mag)
  );

  assign sample_d = quad2_q[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      phase_q    <= '0;
      inc_q      <= '0;
      addr_q     <= '0;
      quad1_q    <= '0;
      quad2_q    <= '0;
      dds_rdy_q  <= 1'b0;
      sample_q   <= MID;
    end else begin
      if (freq_load) begin
        inc_q <= freq_word;
      end
      addr_q    <= addr_d;
      quad1_q   <= phase_hi[LUT_AW+1:LUT_AW];
      quad2_q   <= quad1_q;
      dds_rdy_q <= 1'b0;
      sample_q  <= MID;

      if (!dds_ena) begin
        state_q    <= ST_IDLE;
        fill_cnt_q <= '0;
        phase_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
          end
          // The fill window lets phase 0 travel through the pipeline to the output.
          ST_FILL: begin
            phase_q <= phase_q + inc_q;
            if (fill_cnt_q == FILL_LAST) begin
              state_q   <= ST_RUN;
              dds_rdy_q <= 1'b1;
              sample_q  <= sample_d;
            end else begin
              fill_cnt_q <= fill_cnt_q + 2'd1;
            end
          end
          ST_RUN: begin
            phase_q   <= phase_q + inc_q;
            dds_rdy_q <= 1'b1;
            sample_q  <= sample_d;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign dds_rdy = dds_rdy_q;
  assign sample  = sample_q;

endmodule
